// File: rtl/mem_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module   : mem_arbiter_pkg
// Purpose  : Shared types for the two-port memory arbiter: FSM state encoding
//            and the two-requester vector type used between top and arbiter.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_arbiter_pkg;

    // IDLE grants a request; RDWAIT is the single cycle the memory spends
    // returning read data, during which the port cannot be granted.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_RDWAIT = 1'b1
    } arb_state_e;

    // One bit per requester: bit 0 = m0 (processor), bit 1 = m1 (loader/DMA).
    typedef logic [1:0] port_vec_t;

    localparam int unsigned NUM_PORTS = 2;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
//------------------------------------------------------------------------------
// Module   : mem_arbiter_rr_arb2
// Purpose  : Combinational 2-way arbiter. A lone requester always wins. On a
//            tie, round-robin mode grants the port that did not win last;
//            fixed-priority mode always grants m0.
// Ports    : req_i   [1:0] in  request vector (bit0 = m0, bit1 = m1)
//            last_i        in  index of the most recently granted port
//            rr_en_i       in  1 = round-robin, 0 = m0 fixed priority
//            gnt_o   [1:0] out one-hot grant (or 0 when no request)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter_rr_arb2
    import mem_arbiter_pkg::*;
(
    input  port_vec_t req_i,
    input  logic      last_i,
    input  logic      rr_en_i,
    output port_vec_t gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            // Tie: m1 only wins when round-robin is on and m0 was served last.
            2'b11:   gnt_o = (rr_en_i && !last_i) ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : mem_arbiter
// Purpose  : Shares one synchronous-read memory port between the processor
//            (m0) and a loader/DMA (m1). Writes complete in the grant cycle
//            (one per clock); reads occupy two cycles (strobe, then data).
// Ports    : clk, resetn                 clock, async active-low reset
//            mN_valid/addr/wmask/wdata   requester N command (held until ready)
//            mN_ready                    command accepted this cycle (comb)
//            mN_rvalid/rdata             read data return for requester N
//            mem_addr/wdata/wmask/rstrb  memory command of the granted request
//            mem_rdata                   memory read data (valid cycle after rstrb)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter bit RR     = 1'b1
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                m0_valid,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W/8-1:0] m0_wmask,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic                m0_ready,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,

    input  logic                m1_valid,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W/8-1:0] m1_wmask,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic                m1_ready,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,

    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    output logic                mem_rstrb,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int WMASK_W = DATA_W / 8;

    arb_state_e           state_q, state_d;
    logic                 last_q, last_d;         // index of last granted port
    logic                 rd_owner_q, rd_owner_d; // port awaiting read data
    logic                 rvalid_q, rvalid_d;
    port_vec_t            req, gnt;
    logic [WMASK_W-1:0]   sel_wmask;
    logic                 granted;
    logic                 grant_rd;

    // Requests are only visible to the arbiter while the port is free.
    assign req = (state_q == ST_IDLE) ? {m1_valid, m0_valid} : 2'b00;

    mem_arbiter_rr_arb2 u_arb (
        .req_i   (req),
        .last_i  (last_q),
        .rr_en_i (RR),
        .gnt_o   (gnt)
    );

    always_comb begin
        sel_wmask  = gnt[1] ? m1_wmask : m0_wmask;
        granted    = |gnt;
        grant_rd   = granted && (sel_wmask == '0);

        state_d    = state_q;
        last_d     = last_q;
        rd_owner_d = rd_owner_q;
        rvalid_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (granted) begin
                    last_d = gnt[1];
                    if (grant_rd) begin
                        state_d    = ST_RDWAIT;
                        rd_owner_d = gnt[1];
                        rvalid_d   = 1'b1;
                    end
                end
            end
            ST_RDWAIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;   // m0 wins the first tie
            rd_owner_q <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            rd_owner_q <= rd_owner_d;
            rvalid_q   <= rvalid_d;
        end
    end

    // Handshake and strobes are gated by resetn so nothing is accepted or
    // committed while reset is held, even though the arbiter is combinational.
    assign m0_ready  = resetn & gnt[0];
    assign m1_ready  = resetn & gnt[1];
    assign mem_rstrb = resetn & grant_rd;
    assign mem_wmask = (resetn && granted) ? sel_wmask : '0;

    // With no grant, m0's command is presented (a don't-care for memory).
    assign mem_addr  = gnt[1] ? m1_addr  : m0_addr;
    assign mem_wdata = gnt[1] ? m1_wdata : m0_wdata;

    assign m0_rvalid = rvalid_q & ~rd_owner_q;
    assign m1_rvalid = rvalid_q &  rd_owner_q;
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. Two instances share the
//            requester stimulus: dut0 round-robin, dut1 fixed priority. Each
//            has its own memory and its own reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic [3:0]  m0_wmask = '0, m1_wmask = '0;
    logic [31:0] rd0, rd1;

    wire [1:0]       m0_ready_v, m1_ready_v, m0_rvalid_v, m1_rvalid_v, rstrb_v;
    wire [1:0][31:0] m0_rdata_v, m1_rdata_v, maddr_v, mwdata_v;
    wire [1:0][3:0]  mwmask_v;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR(1'b1)) dut0 (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wmask(m0_wmask), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready_v[0]), .m0_rvalid(m0_rvalid_v[0]), .m0_rdata(m0_rdata_v[0]),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wmask(m1_wmask), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready_v[0]), .m1_rvalid(m1_rvalid_v[0]), .m1_rdata(m1_rdata_v[0]),
        .mem_addr(maddr_v[0]), .mem_wdata(mwdata_v[0]), .mem_wmask(mwmask_v[0]),
        .mem_rstrb(rstrb_v[0]), .mem_rdata(rd0)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR(1'b0)) dut1 (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wmask(m0_wmask), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready_v[1]), .m0_rvalid(m0_rvalid_v[1]), .m0_rdata(m0_rdata_v[1]),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wmask(m1_wmask), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready_v[1]), .m1_rvalid(m1_rvalid_v[1]), .m1_rdata(m1_rdata_v[1]),
        .mem_addr(maddr_v[1]), .mem_wdata(mwdata_v[1]), .mem_wmask(mwmask_v[1]),
        .mem_rstrb(rstrb_v[1]), .mem_rdata(rd1)
    );

    // Memories: data one cycle after rstrb, byte writes commit on the clock edge.
    logic [31:0] mem0 [64];
    logic [31:0] mem1 [64];

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem0[i] <= 32'hC0DE_0000 + i;
            mem1[i] <= 32'hC0DE_0000 + i;
        end
    end

    always @(posedge clk) begin
        if (rstrb_v[0]) rd0 <= mem0[maddr_v[0][7:2]];
        for (int b = 0; b < 4; b++)
            if (mwmask_v[0][b]) mem0[maddr_v[0][7:2]][8*b +: 8] <= mwdata_v[0][8*b +: 8];
    end

    always @(posedge clk) begin
        if (rstrb_v[1]) rd1 <= mem1[maddr_v[1][7:2]];
        for (int b = 0; b < 4; b++)
            if (mwmask_v[1][b]) mem1[maddr_v[1][7:2]][8*b +: 8] <= mwdata_v[1][8*b +: 8];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Per instance: the memory image, the outstanding read (owner, address)
    // that must be returned next cycle, and who won the previous grant.
    logic [31:0] mmem [2][64];
    int          pend  [2];
    logic [31:0] paddr [2];
    int          lastg [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            pend[k]  = -1;
            lastg[k] = 1;
            for (int i = 0; i < 64; i++) mmem[k][i] = 32'hC0DE_0000 + i;
        end
    end

    task automatic model_step(input int k);
        logic [1:0]  e_ready, e_rvalid;
        logic        e_rstrb;
        logic [3:0]  e_wmask, wm;
        logic [31:0] a, wd, rdat;
        int          w;
        e_ready = 2'b00; e_rvalid = 2'b00; e_rstrb = 1'b0; e_wmask = 4'h0;
        w = -1; a = '0; wd = '0;
        if (!resetn) begin
            pend[k]  = -1;
            lastg[k] = 1;
        end else if (pend[k] >= 0) begin
            e_rvalid[pend[k]] = 1'b1;
            rdat = (pend[k] == 0) ? m0_rdata_v[k] : m1_rdata_v[k];
            chk($sformatf("dut%0d rdata", k), rdat, mmem[k][paddr[k][7:2]]);
            pend[k] = -1;
        end else begin
            if (m0_valid && m1_valid) w = (k == 0 && lastg[k] == 0) ? 1 : 0;
            else if (m0_valid)        w = 0;
            else if (m1_valid)        w = 1;
            if (w >= 0) begin
                a  = (w == 0) ? m0_addr  : m1_addr;
                wd = (w == 0) ? m0_wdata : m1_wdata;
                wm = (w == 0) ? m0_wmask : m1_wmask;
                e_ready[w] = 1'b1;
                e_wmask    = wm;
                e_rstrb    = (wm == 4'h0);
                lastg[k]   = w;
                if (wm == 4'h0) begin
                    pend[k]  = w;
                    paddr[k] = a;
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (wm[b]) mmem[k][a[7:2]][8*b +: 8] = wd[8*b +: 8];
                end
            end
        end
        chk($sformatf("dut%0d ready", k),  {30'd0, m1_ready_v[k], m0_ready_v[k]}, {30'd0, e_ready});
        chk($sformatf("dut%0d rvalid", k), {30'd0, m1_rvalid_v[k], m0_rvalid_v[k]}, {30'd0, e_rvalid});
        chk($sformatf("dut%0d rstrb", k),  {31'd0, rstrb_v[k]}, {31'd0, e_rstrb});
        chk($sformatf("dut%0d wmask", k),  {28'd0, mwmask_v[k]}, {28'd0, e_wmask});
        if (w >= 0) begin
            chk($sformatf("dut%0d mem_addr", k), maddr_v[k], a);
            if (e_wmask != 4'h0) chk($sformatf("dut%0d mem_wdata", k), mwdata_v[k], wd);
        end
    endtask

    always @(negedge clk) begin
        model_step(0);
        model_step(1);
    end

    // Protocol: a requester must not drop valid before it is accepted (dut0 handshake).
    bit pend0_req = 1'b0, pend1_req = 1'b0;
    always @(negedge clk) begin
        if (!resetn) begin
            pend0_req <= 1'b0;
            pend1_req <= 1'b0;
        end else begin
            assert (!(pend0_req && !m0_valid)) else $error("FAIL protocol: m0 valid dropped before ready");
            assert (!(pend1_req && !m1_valid)) else $error("FAIL protocol: m1 valid dropped before ready");
            pend0_req <= m0_valid && !m0_ready_v[0];
            pend1_req <= m1_valid && !m1_ready_v[0];
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int m, input bit v, input logic [31:0] a,
                         input logic [3:0] wm, input logic [31:0] wd);
        if (m == 0) begin m0_valid = v; m0_addr = a; m0_wmask = wm; m0_wdata = wd; end
        else        begin m1_valid = v; m1_addr = a; m1_wmask = wm; m1_wdata = wd; end
    endtask

    task automatic wait_ready(input int m, input string nm);
        int n;
        bit got;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            got = (m == 0) ? m0_ready_v[0] : m1_ready_v[0];
            n++;
        end
        chk({nm, " ready"}, {31'd0, got}, 32'd1);
    endtask

    task automatic read_txn(input int m, input logic [31:0] a, input logic [31:0] exp, input string nm);
        @(posedge clk); #1;
        drive(m, 1'b1, a, 4'h0, 32'h0);
        wait_ready(m, nm);
        chk({nm, " rstrb"}, {31'd0, rstrb_v[0]}, 32'd1);
        @(posedge clk); #1;
        drive(m, 1'b0, a, 4'h0, 32'h0);
        @(negedge clk);
        chk({nm, " rvalid"}, {31'd0, (m == 0) ? m0_rvalid_v[0] : m1_rvalid_v[0]}, 32'd1);
        chk({nm, " rdata"}, (m == 0) ? m0_rdata_v[0] : m1_rdata_v[0], exp);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        resetn = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int wr_cnt, g0, g1, d1m0, d1m1, rep, prev, first, cnt1, n;
        bit got;

        // 1: m0 read held through reset; nothing accepted until release.
        drive(0, 1'b1, 32'h10, 4'h0, 32'h0);
        @(negedge clk);
        chk("t1 reset ready", {30'd0, m1_ready_v[0], m0_ready_v[0]}, 32'd0);
        chk("t1 reset rstrb", {31'd0, rstrb_v[0]}, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("t1 ready same cycle", {31'd0, m0_ready_v[0]}, 32'd1);
        chk("t1 rstrb", {31'd0, rstrb_v[0]}, 32'd1);
        chk("t1 addr", maddr_v[0], 32'h10);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'h10, 4'h0, 32'h0);
        @(negedge clk);
        chk("t1 rvalid", {31'd0, m0_rvalid_v[0]}, 32'd1);
        chk("t1 rdata", m0_rdata_v[0], 32'hC0DE_0004);
        chk("t1 no rstrb in wait", {31'd0, rstrb_v[0]}, 32'd0);

        // 2: simultaneous reads straight out of reset.
        pulse_reset();
        @(posedge clk); #1;
        drive(0, 1'b1, 32'h04, 4'h0, 32'h0);
        drive(1, 1'b1, 32'h14, 4'h0, 32'h0);
        @(negedge clk);
        chk("t2 T m0 ready", {31'd0, m0_ready_v[0]}, 32'd1);
        chk("t2 T m1 ready", {31'd0, m1_ready_v[0]}, 32'd0);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'h04, 4'h0, 32'h0);
        @(negedge clk);
        chk("t2 T+1 m0 rvalid", {31'd0, m0_rvalid_v[0]}, 32'd1);
        chk("t2 T+1 m0 rdata", m0_rdata_v[0], 32'hC0DE_0001);
        chk("t2 T+1 m1 ready", {31'd0, m1_ready_v[0]}, 32'd0);
        @(negedge clk);
        chk("t2 T+2 m1 ready", {31'd0, m1_ready_v[0]}, 32'd1);
        chk("t2 T+2 m1 ready rr0", {31'd0, m1_ready_v[1]}, 32'd1);
        chk("t2 T+2 addr", maddr_v[0], 32'h14);
        @(posedge clk); #1;
        drive(1, 1'b0, 32'h14, 4'h0, 32'h0);
        @(negedge clk);
        chk("t2 T+3 m1 rvalid", {31'd0, m1_rvalid_v[0]}, 32'd1);
        chk("t2 T+3 m1 rdata", m1_rdata_v[0], 32'hC0DE_0005);

        // 3: four back-to-back m1 writes.
        @(posedge clk); #1;
        drive(1, 1'b1, 32'h20, 4'hF, 32'hDEAD_BEEF);
        wr_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (m1_ready_v[0] && mwmask_v[0] == 4'hF && !rstrb_v[0]) wr_cnt++;
        end
        @(posedge clk); #1;
        drive(1, 1'b0, 32'h20, 4'h0, 32'h0);
        chk("t3 writes in 4 cycles", wr_cnt, 32'd4);
        read_txn(0, 32'h20, 32'hDEAD_BEEF, "t3 readback");

        // 4: m0 read and m1 write both held continuously.
        @(posedge clk); #1;
        drive(0, 1'b1, 32'h00, 4'h0, 32'h0);
        drive(1, 1'b1, 32'h30, 4'hF, 32'h1111_1111);
        g0 = 0; g1 = 0; d1m0 = 0; d1m1 = 0; rep = 0; prev = -1; first = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (m0_ready_v[0] || m1_ready_v[0]) begin
                if (first < 0) first = m1_ready_v[0] ? 1 : 0;
                if (prev == (m1_ready_v[0] ? 1 : 0)) rep++;
                prev = m1_ready_v[0] ? 1 : 0;
            end
            if (m0_ready_v[0]) g0++;
            if (m1_ready_v[0]) g1++;
            if (m0_ready_v[1]) d1m0++;
            if (m1_ready_v[1]) d1m1++;
        end
        chk("t4 rr first grant m1", first, 32'd1);
        chk("t4 rr m0 grants", g0, 32'd4);
        chk("t4 rr m1 grants", g1, 32'd4);
        chk("t4 rr repeats", rep, 32'd0);
        chk("t4 fixed m0 grants", d1m0, 32'd6);
        chk("t4 fixed m1 starved", d1m1, 32'd0);
        wait_ready(0, "t4 drain m0");
        @(posedge clk); #1;
        drive(0, 1'b0, 32'h00, 4'h0, 32'h0);
        n = 0; got = 1'b0; cnt1 = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            if (m1_ready_v[1]) cnt1++;
            got = m1_ready_v[0];
            n++;
        end
        chk("t4 drain m1 ready", {31'd0, got}, 32'd1);
        chk("t4 fixed m1 served after m0 drops", {31'd0, (cnt1 > 0)}, 32'd1);
        @(posedge clk); #1;
        drive(1, 1'b0, 32'h30, 4'h0, 32'h0);

        // 5: partial write then read of merged word.
        @(posedge clk); #1;
        drive(1, 1'b1, 32'h08, 4'b0011, 32'h1234_5678);
        wait_ready(1, "t5 write");
        chk("t5 wmask passthrough", {28'd0, mwmask_v[0]}, 32'h3);
        @(posedge clk); #1;
        drive(1, 1'b0, 32'h08, 4'h0, 32'h0);
        read_txn(0, 32'h08, 32'hC0DE_5678, "t5 merged");

        // 6: reset during the data-return cycle.
        @(posedge clk); #1;
        drive(0, 1'b1, 32'h0C, 4'h0, 32'h0);
        wait_ready(0, "t6 read");
        @(posedge clk); #1;
        drive(0, 1'b0, 32'h0C, 4'h0, 32'h0);
        resetn = 1'b0;
        @(negedge clk);
        chk("t6 rvalid killed rr", {31'd0, m0_rvalid_v[0]}, 32'd0);
        chk("t6 rvalid killed fixed", {31'd0, m0_rvalid_v[1]}, 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        resetn = 1'b1;
        read_txn(0, 32'h0C, 32'hC0DE_0003, "t6 reissue");

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
